// File: rtl/multi_digit_display.sv
// Multiplexed 7-segment driver: hex or decimal (sequential double-dabble) display with
// leading-zero blanking, per-digit decimal points, overflow dashes and a Load/Busy handshake.
module multi_digit_display #(
    parameter int NUM_DIGITS = 8,
    parameter int DATA_W     = 32,
    parameter int DIV_W      = 17,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_W-1:0]     Number,
    input  logic                  Load,
    input  logic                  HexMode,
    input  logic                  BlankLZ,
    input  logic [NUM_DIGITS-1:0] DpMask,
    output logic                  Busy,
    output logic                  Overflow,
    output logic [6:0]            out7,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] en_out
);

    // Smallest digit count whose decimal range covers every DATA_W-bit value.
    function automatic int bcd_digits(input int w);
        longint unsigned lim;
        longint unsigned p;
        int              n;
        lim = 64'd1 << w;
        p   = 64'd1;
        n   = 0;
        for (int i = 0; i < 12; i++) begin
            if (p < lim) begin
                p = p * 10;
                n++;
            end
        end
        return n;
    endfunction

    localparam int   BCD_N = bcd_digits(DATA_W);
    localparam int   CNT_W = $clog2(DATA_W);
    localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int   HEX_W = (DATA_W > 4*NUM_DIGITS) ? DATA_W : 4*NUM_DIGITS;
    localparam int   BCD_W = (BCD_N > NUM_DIGITS) ? 4*BCD_N : 4*NUM_DIGITS;
    localparam logic POL   = (ACTIVE_LOW != 0);

    localparam logic [6:0] SEG_ZERO = 7'b1111110;
    localparam logic [6:0] SEG_DASH = 7'b0000001;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0:    return 7'b1111110;
            4'h1:    return 7'b0110000;
            4'h2:    return 7'b1101101;
            4'h3:    return 7'b1111001;
            4'h4:    return 7'b0110011;
            4'h5:    return 7'b1011011;
            4'h6:    return 7'b1011111;
            4'h7:    return 7'b1110000;
            4'h8:    return 7'b1111111;
            4'h9:    return 7'b1111011;
            4'hA:    return 7'b1110111;
            4'hB:    return 7'b0011111;
            4'hC:    return 7'b1001110;
            4'hD:    return 7'b0111101;
            4'hE:    return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    logic                       busy_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [DATA_W-1:0]          shift_q;
    logic [4*BCD_N-1:0]         bcd_q;
    logic [NUM_DIGITS-1:0][3:0] digits_q;
    logic                       ovf_q;
    logic                       blank_q, pend_blank_q;
    logic [NUM_DIGITS-1:0]      dpm_q, pend_dp_q;
    logic [DIV_W-1:0]           div_q;
    logic [IDX_W-1:0]           idx_q;
    logic [6:0]                 out7_q;
    logic                       dp_q;
    logic [NUM_DIGITS-1:0]      en_q;

    logic [HEX_W-1:0]           hex_ext;
    logic [NUM_DIGITS-1:0][3:0] hex_digits_d, dec_digits_d;
    logic                       hex_ovf_d, dec_ovf_d;
    logic [4*BCD_N-1:0]         bcd_adj, bcd_d;
    logic [BCD_W-1:0]           bcd_ext;
    logic [NUM_DIGITS-1:0]      blank_vec_d;
    logic                       zero_above;
    logic [6:0]                 seg_d;
    logic [NUM_DIGITS-1:0]      en_d;

    assign hex_ext   = HEX_W'(Number);
    assign hex_ovf_d = |(hex_ext >> (4*NUM_DIGITS));
    assign bcd_ext   = BCD_W'(bcd_d);
    assign dec_ovf_d = |(bcd_ext >> (4*NUM_DIGITS));

    // One shift-add-3 iteration: correct every BCD nibble >= 5, then shift in the next bit.
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d = (bcd_adj << 1) | {{(4*BCD_N-1){1'b0}}, shift_q[DATA_W-1]};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            hex_digits_d[k] = hex_ext[4*k +: 4];
            dec_digits_d[k] = bcd_ext[4*k +: 4];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            shift_q      <= '0;
            bcd_q        <= '0;
            digits_q     <= '0;
            ovf_q        <= 1'b0;
            blank_q      <= 1'b0;
            pend_blank_q <= 1'b0;
            dpm_q        <= '0;
            pend_dp_q    <= '0;
        end else if (!busy_q) begin
            if (Load) begin
                if (HexMode) begin
                    digits_q <= hex_digits_d;
                    ovf_q    <= hex_ovf_d;
                    blank_q  <= BlankLZ;
                    dpm_q    <= DpMask;
                end else begin
                    busy_q       <= 1'b1;
                    cnt_q        <= '0;
                    shift_q      <= Number;
                    bcd_q        <= '0;
                    pend_blank_q <= BlankLZ;
                    pend_dp_q    <= DpMask;
                end
            end
        end else begin
            shift_q <= shift_q << 1;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_q + CNT_W'(1);
            // Last iteration: publish digits, overflow and display modes in one edge.
            if (cnt_q == CNT_W'(DATA_W-1)) begin
                busy_q   <= 1'b0;
                digits_q <= dec_digits_d;
                ovf_q    <= dec_ovf_d;
                blank_q  <= pend_blank_q;
                dpm_q    <= pend_dp_q;
            end
        end
    end

    always_comb begin
        zero_above  = 1'b1;
        blank_vec_d = '0;
        for (int k = NUM_DIGITS-1; k >= 0; k--) begin
            blank_vec_d[k] = blank_q && zero_above && (digits_q[k] == 4'd0) &&
                             (k != 0) && !dpm_q[k];
            if (digits_q[k] != 4'd0) zero_above = 1'b0;
        end
        if (ovf_q)                   seg_d = SEG_DASH;
        else if (blank_vec_d[idx_q]) seg_d = 7'b0000000;
        else                         seg_d = glyph(digits_q[idx_q]);
        en_d = NUM_DIGITS'(1) << idx_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            div_q  <= '0;
            idx_q  <= '0;
            out7_q <= SEG_ZERO ^ {7{POL}};
            dp_q   <= POL;
            en_q   <= NUM_DIGITS'(1) ^ {NUM_DIGITS{POL}};
        end else begin
            div_q <= div_q + DIV_W'(1);
            if (&div_q) idx_q <= (idx_q == IDX_W'(NUM_DIGITS-1)) ? '0 : idx_q + IDX_W'(1);
            out7_q <= seg_d ^ {7{POL}};
            dp_q   <= dpm_q[idx_q] ^ POL;
            en_q   <= en_d ^ {NUM_DIGITS{POL}};
        end
    end

    assign Busy     = busy_q;
    assign Overflow = ovf_q;
    assign out7     = out7_q;
    assign dp_out   = dp_q;
    assign en_out   = en_q;

endmodule
